aes_block_serializer: RTL and testbench
=======================================

# aes_block_serializer

Output-side stage of the AES HWPE datapath: consumes 128-bit result blocks from the AES engine and emits them as 32-bit words on the streamer-facing output stream. It sends a programmed number of blocks per job with valid/ready back-pressure on both sides. It flags the final word of the job and reports completion to the HWPE controller. The block-side handshake overlaps with the last word so back-to-back blocks stream without bubbles.

## Interface
- BLOCK_W, 128, block width in bits; fixed at 4 × WORD_W.
- WORD_W, 32, output word width in bits.
- CNT_W, 16, width of block count and job length.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, reset is asynchronous and active-low.
- clear_i  in  1  synchronous soft clear from controller.
- start_i  in  1  job start pulse; honoured only in IDLE.
- nblocks_i  in  CNT_W  blocks in job; sampled on accepted start_i.
- blk_valid_i  in  1  engine has a result block.
- blk_ready_o  out  1  serializer takes block this cycle.
- blk_data_i  in  BLOCK_W  result block; word k = bits [32k+31:32k].
- word_valid_o  out  1  output word valid.
- word_ready_i  in  1  downstream accepts word.
- word_data_o  out  WORD_W  output word.
- word_strb_o  out  WORD_W/8  byte strobes; always all ones while valid, 0 otherwise.
- word_last_o  out  1  marks word 3 of the final block of the job.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle completion pulse.
- blk_cnt_o  out  CNT_W  blocks fully sent in current job.

## Operation
- States: IDLE, LOAD, SEND, DONE.
- IDLE: on start_i, latch nblocks_i and clear blk_cnt.
  - nblocks_i == 0: go to DONE.
  - Otherwise: go to LOAD.
- LOAD: blk_ready_o = 1. On blk_valid_i:
  - Capture blk_data_i into a 128-bit holding register.
  - Set word index idx = 0 and go to SEND.
- SEND:
  - word_valid_o = 1, word_data_o = hold[32·idx +: 32].
  - On word handshake (valid & ready): idx increments 0→1→2→3.
  - On handshake at idx == 3: blk_cnt increments.
    - Final block: go to DONE.
    - Otherwise: go to LOAD, unless overlap applies (next bullet).
- Overlap: in SEND with idx == 3 and word_ready_i = 1 and not the final block, blk_ready_o = 1.
  - If blk_valid_i is also high, the new block is captured, idx returns to 0 and the state stays SEND.
  - This is a combinational path word_ready_i → blk_ready_o.
- DONE: done_o = 1 for exactly one cycle, then IDLE.
- Words leave in order 0,1,2,3 (LSW first).
- Once word_valid_o rises, word_valid_o and word_data_o stay stable until the handshake.
- blk_cnt counts modulo 2^CNT_W. A job always ends when blk_cnt equals the latched nblocks.
- start_i outside IDLE is ignored. The latched job length is not changed.
- clear_i has priority over all other inputs. Next cycle:
  - State is IDLE.
  - idx, blk_cnt and the holding register are 0.
  - word_valid_o is 0 and no done_o pulse is issued.
  - A partially sent block is dropped.
- Asynchronous reset mid-job has the same effect as clear_i, applied immediately.

## Timing
- Reset values:
  - blk_ready_o, word_valid_o, word_last_o, busy_o, done_o: 0.
  - word_data_o, word_strb_o, blk_cnt_o: 0.
- Block accepted at cycle N → word 0 valid at N+1.
- With word_ready_i held high, words 0..3 occupy N+1..N+4.
- Back-to-back blocks with both sides always ready: one word per cycle, zero bubbles.
  - Block i+1 is accepted in the same cycle as word 3 of block i.
- Job completion timing:
  - Last word handshake at cycle M → done_o at M+1.
  - blk_cnt_o shows the final count from M+1.
  - busy_o falls at M+2.
- nblocks_i == 0: start_i at cycle S → done_o at S+1, busy_o high only during S+1. No words emitted.
- blk_ready_o never depends on blk_valid_i. word_valid_o never depends on word_ready_i.

## Test plan
- Single block: nblocks=1, block 0x33333333_22222222_11111111_00000000, ready always 1 → words 0x00000000, 0x11111111, 0x22222222, 0x33333333 on four consecutive cycles; word_last_o only on the 4th; done_o one cycle later; blk_cnt_o=1.
- Back-pressure: nblocks=1, word_ready_i toggling 1,0,0,1,1,0,1 → each word held stable while stalled; exactly 4 handshakes in order; no extra words; done_o once.
- Streaming: nblocks=3, blk_valid_i and word_ready_i always 1 → 12 words on 12 consecutive cycles; blk_ready_o high together with word 3 of blocks 0 and 1, but not with word 3 of block 2; word_last_o only on word 12; blk_cnt_o ends at 3.
- Zero-length job: nblocks=0 → no word_valid_o; done_o at start+1; blk_ready_o never asserted.
- Clear mid-block: nblocks=2, clear_i after word 1 of block 0 → next cycle IDLE, outputs zero, no done_o. A new job with nblocks=1 then runs normally from word 0 of a fresh block.
- Reset and ignored start: rst_ni low during SEND → all outputs 0 asynchronously. After release, start_i issued while busy with nblocks=5 on a 1-block job → job still ends after 1 block.

Source files
------------

// File: rtl/aes_block_serializer.sv
// AES result serializer: 128-bit blocks in, 32-bit words out (LSW first).
// Counts blocks per job, flags the final word and pulses done on completion.
module aes_block_serializer #(
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               start_i,
  input  logic [CNT_W-1:0]   nblocks_i,
  input  logic               blk_valid_i,
  output logic               blk_ready_o,
  input  logic [BLOCK_W-1:0] blk_data_i,
  output logic               word_valid_o,
  input  logic               word_ready_i,
  output logic [WORD_W-1:0]  word_data_o,
  output logic [WORD_W/8-1:0] word_strb_o,
  output logic               word_last_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   blk_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   nblk_q, nblk_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [BLOCK_W-1:0] hold_q, hold_d;
  logic [1:0]         idx_q, idx_d;
  logic               w_hs, b_hs;
  logic               last_word, last_blk;

  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign last_word = (idx_q == 2'd3);
  assign last_blk  = (cnt_inc == nblk_q);

  assign word_valid_o = (state_q == SEND);
  // Overlap: take the next block while word 3 is being accepted.
  assign blk_ready_o  = (state_q == LOAD)
                      | (word_valid_o & last_word
                         & word_ready_i & ~last_blk);

  assign w_hs = word_valid_o & word_ready_i;
  assign b_hs = blk_valid_i & blk_ready_o;

  assign word_data_o = word_valid_o
                     ? hold_q[idx_q*WORD_W +: WORD_W]
                     : '0;
  assign word_strb_o = {(WORD_W/8){word_valid_o}};
  assign word_last_o = word_valid_o & last_word & last_blk;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign blk_cnt_o   = cnt_q;

  always_comb begin
    state_d = state_q;
    nblk_d  = nblk_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      hold_d  = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            nblk_d  = nblocks_i;
            cnt_d   = '0;
            state_d = (nblocks_i == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (blk_valid_i) begin
            hold_d  = blk_data_i;
            idx_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (w_hs) begin
            idx_d = idx_q + 2'd1;
            if (last_word) begin
              cnt_d = cnt_inc;
              if (last_blk) begin
                state_d = DONE;
              end else if (b_hs) begin
                hold_d = blk_data_i;
              end else begin
                state_d = LOAD;
              end
            end
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      nblk_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      nblk_q  <= nblk_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_aes_block_serializer.sv
// Bench for aes_block_serializer: directed timing cases plus
// randomized jobs checked against a per-job expected word queue.
module tb_aes_block_serializer;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         clear_i = 1'b0;
  logic         start_i = 1'b0;
  logic [15:0]  nblocks_i = '0;
  logic         blk_valid_i = 1'b0;
  logic         blk_ready_o;
  logic [127:0] blk_data_i = '0;
  logic         word_valid_o;
  logic         word_ready_i = 1'b0;
  logic [31:0]  word_data_o;
  logic [3:0]   word_strb_o;
  logic         word_last_o;
  logic         busy_o;
  logic         done_o;
  logic [15:0]  blk_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  aes_block_serializer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .start_i(start_i), .nblocks_i(nblocks_i),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o),
    .blk_data_i(blk_data_i),
    .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .word_data_o(word_data_o), .word_strb_o(word_strb_o),
    .word_last_o(word_last_o), .busy_o(busy_o),
    .done_o(done_o), .blk_cnt_o(blk_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_bready"}, blk_ready_o, 0);
    check({tag, "_wvalid"}, word_valid_o, 0);
    check({tag, "_wdata"}, word_data_o, 0);
    check({tag, "_strb"}, word_strb_o, 0);
    check({tag, "_last"}, word_last_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
  endtask

  function automatic logic [127:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One job of n blocks; expected output is every word of every
  // offered block in LSW-first order, last flag on the very last.
  task automatic run_job(input int n, input int pv,
                         input int pr, input bit mid);
    logic [127:0] blks[$];
    exp_t q[$];
    exp_t e;
    logic [127:0] b;
    logic [31:0] sd;
    int offered = 0;
    int cyc = 0;
    bit taken = 0;
    bit stall = 0;
    bit fin = 0;
    for (int i = 0; i < n; i++) begin
      b = rnd_blk();
      blks.push_back(b);
      for (int k = 0; k < 4; k++)
        q.push_back('{b[32*k +: 32], (i == n-1) && (k == 3)});
    end
    while (!fin && cyc < 600) begin
      @(posedge clk_i); #1;
      start_i = (cyc == 0) || (mid && cyc == 4);
      if (cyc == 0) nblocks_i = 16'(n);
      else if (mid) nblocks_i = 16'd5;
      if (taken) begin
        blk_valid_i = 1'b0;
        taken = 0;
      end
      if (!blk_valid_i && offered < n && cyc > 0
          && $urandom_range(99) < pv) begin
        blk_valid_i = 1'b1;
        blk_data_i  = blks[offered];
      end
      word_ready_i = ($urandom_range(99) < pr);
      cyc++;
      @(negedge clk_i);
      if (stall) begin
        check("hold_valid", word_valid_o, 1);
        check("hold_data", word_data_o, sd);
      end
      if (word_valid_o) check("strb", word_strb_o, 4'hf);
      stall = word_valid_o && !word_ready_i;
      sd = word_data_o;
      if (word_valid_o && word_ready_i) begin
        if (q.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          e = q.pop_front();
          check("word", word_data_o, e.d);
          check("last", word_last_o, e.l);
        end
      end
      if (blk_valid_i && blk_ready_o) begin
        taken = 1;
        offered++;
      end
      if (done_o) begin
        check("done_cnt", blk_cnt_o, 16'(n));
        fin = 1;
      end
    end
    start_i = 1'b0;
    blk_valid_i = 1'b0;
    check("job_done_seen", fin, 1);
    check("words_left", q.size(), 0);
    check("blocks_taken", offered, n);
    @(negedge clk_i);
    check("busy_after", busy_o, 0);
    check("done_once", done_o, 0);
  endtask

  logic [127:0] sb[3];
  logic [127:0] cb;
  int p;

  initial begin
    #3;
    check_idle("rst");
    check("rst_cnt", blk_cnt_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Streaming: three blocks, both sides always ready.
    for (int i = 0; i < 3; i++) sb[i] = rnd_blk();
    @(posedge clk_i); #1;
    start_i = 1; nblocks_i = 16'd3;
    blk_valid_i = 1; blk_data_i = sb[0]; word_ready_i = 1;
    @(posedge clk_i); #1;
    start_i = 0;
    @(negedge clk_i);
    check("st_load_ready", blk_ready_o, 1);
    check("st_load_valid", word_valid_o, 0);
    @(posedge clk_i); #1;
    blk_data_i = sb[1];
    p = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      check("st_valid", word_valid_o, 1);
      check("st_word", word_data_o, sb[k/4][32*(k%4) +: 32]);
      check("st_bready", blk_ready_o, (k % 4 == 3) && (k / 4 < 2));
      check("st_last", word_last_o, k == 11);
      @(posedge clk_i); #1;
      if (k % 4 == 3) begin
        p++;
        if (p < 3) blk_data_i = sb[p];
        else blk_valid_i = 0;
      end
    end
    @(negedge clk_i);
    check("st_done", done_o, 1);
    check("st_cnt", blk_cnt_o, 3);
    check("st_valid_end", word_valid_o, 0);
    check("st_busy_m1", busy_o, 1);
    @(negedge clk_i);
    check("st_busy_m2", busy_o, 0);
    check("st_done_m2", done_o, 0);

    // Zero-length job.
    @(posedge clk_i); #1;
    start_i = 1; nblocks_i = 16'd0; blk_valid_i = 1;
    @(posedge clk_i); #1;
    start_i = 0;
    @(negedge clk_i);
    check("z_done", done_o, 1);
    check("z_busy", busy_o, 1);
    check("z_valid", word_valid_o, 0);
    check("z_bready", blk_ready_o, 0);
    @(negedge clk_i);
    check_idle("z_after");
    blk_valid_i = 0;

    // Clear after word 1 of block 0.
    cb = rnd_blk();
    @(posedge clk_i); #1;
    start_i = 1; nblocks_i = 16'd2;
    blk_valid_i = 1; blk_data_i = cb; word_ready_i = 1;
    @(posedge clk_i); #1;
    start_i = 0;
    @(posedge clk_i); #1;
    blk_valid_i = 0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("cl_w1", word_data_o, cb[63:32]);
    @(posedge clk_i); #1;
    clear_i = 1;
    @(posedge clk_i); #1;
    clear_i = 0;
    @(negedge clk_i);
    check_idle("cl");
    check("cl_cnt", blk_cnt_o, 0);
    run_job(1, 100, 100, 0);

    // Async reset during SEND, then start ignored while busy.
    @(posedge clk_i); #1;
    start_i = 1; nblocks_i = 16'd1;
    blk_valid_i = 1; blk_data_i = rnd_blk(); word_ready_i = 0;
    @(posedge clk_i); #1;
    start_i = 0;
    @(posedge clk_i); #1;
    blk_valid_i = 0;
    @(negedge clk_i);
    check("ar_pre_valid", word_valid_o, 1);
    #1 rst_ni = 1'b0;
    #1;
    check_idle("ar");
    check("ar_cnt", blk_cnt_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_job(1, 100, 100, 1);

    // Back-pressure and randomized jobs.
    run_job(1, 100, 50, 0);
    for (int j = 0; j < 25; j++)
      run_job($urandom_range(5), $urandom_range(30, 100),
              $urandom_range(20, 100), j[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
